// File: rtl/icb_master.sv
// Single-outstanding ICB bus master: turns one local request into an ICB command,
// waits for the response (bounded by TIMEOUT) and emits a one-cycle completion report.
module icb_master #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,

  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_addr,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,

  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err,

  output logic        done_valid,
  output logic [31:0] done_rdata,
  output logic        done_err,
  output logic        done_timeout
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the valid side holds its payload stable and never withdraws valid before that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        read_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [15:0] wait_q, wait_d;
  logic        done_valid_q, done_valid_d;
  logic [31:0] done_rdata_q, done_rdata_d;
  logic        done_err_q, done_err_d;
  logic        done_timeout_q, done_timeout_d;

  logic req_fire;
  logic cmd_fire;
  logic timeout_hit;

  assign req_ready     = (state_q == IDLE);
  assign icb_cmd_valid = (state_q == CMD);
  // Ready in IDLE too, so a late response after a timeout is drained silently.
  assign icb_rsp_ready = (state_q != CMD);

  assign icb_cmd_read  = read_q;
  assign icb_cmd_addr  = addr_q;
  assign icb_cmd_wdata = wdata_q;
  assign icb_cmd_wmask = read_q ? 4'h0 : wmask_q;

  assign done_valid    = done_valid_q;
  assign done_rdata    = done_rdata_q;
  assign done_err      = done_err_q;
  assign done_timeout  = done_timeout_q;

  assign req_fire    = req_valid & req_ready;
  assign cmd_fire    = icb_cmd_valid & icb_cmd_ready;
  assign timeout_hit = TIMEOUT_EN && (state_q == RSP) && !icb_rsp_valid &&
                       (wait_q == WAIT_LAST);

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    done_valid_d   = 1'b0;
    done_rdata_d   = done_rdata_q;
    done_err_d     = done_err_q;
    done_timeout_d = done_timeout_q;
    case (state_q)
      IDLE: begin
        if (req_fire) state_d = CMD;
      end
      CMD: begin
        if (cmd_fire) begin
          state_d = RSP;
          wait_d  = 16'h0;
        end
      end
      RSP: begin
        // A response in the final wait cycle still wins over the timeout.
        if (icb_rsp_valid) begin
          state_d        = IDLE;
          done_valid_d   = 1'b1;
          done_rdata_d   = read_q ? icb_rsp_rdata : 32'h0;
          done_err_d     = icb_rsp_err;
          done_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d        = IDLE;
          done_valid_d   = 1'b1;
          done_rdata_d   = 32'h0;
          done_err_d     = 1'b1;
          done_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_q         <= 16'h0;
      done_valid_q   <= 1'b0;
      done_rdata_q   <= 32'h0;
      done_err_q     <= 1'b0;
      done_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      done_valid_q   <= done_valid_d;
      done_rdata_q   <= done_rdata_d;
      done_err_q     <= done_err_d;
      done_timeout_q <= done_timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
    end else if (req_fire) begin
      read_q  <= req_read;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

endmodule

// File: tb/tb_icb_master.sv
// Directed bench for icb_master (TIMEOUT=8): drives local requests and a scripted
// ICB slave, checks every cycle at the falling edge against hand-computed values.
module tb_icb_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        done_err;
  logic        done_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  icb_master #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_read      (req_read),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .done_valid    (done_valid),
    .done_rdata    (done_rdata),
    .done_err      (done_err),
    .done_timeout  (done_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // driver: one full transaction from an IDLE falling edge to the done_valid cycle
  task automatic do_txn(input string tag, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input int cmd_wait, input int rsp_wait,
                        input logic [31:0] rdata, input logic err);
    logic [3:0] exp_mask;
    exp_mask = rd ? 4'h0 : mask;
    chk($sformatf("%s_req_ready", tag), req_ready, 1'b1);
    req_valid = 1'b1; req_read = rd; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    icb_cmd_ready = 1'b0;
    exp_q.push_back(rd ? rdata : 32'h0);
    step();
    // scramble the request bus to prove the command comes from latched copies
    req_valid = 1'b0; req_read = ~rd; req_addr = ~addr; req_wdata = ~wdata; req_wmask = ~mask;
    for (int i = 0; i <= cmd_wait; i++) begin
      chk($sformatf("%s_cmd_valid%0d", tag, i), icb_cmd_valid, 1'b1);
      chk($sformatf("%s_cmd_read%0d", tag, i), icb_cmd_read, rd);
      chk($sformatf("%s_cmd_addr%0d", tag, i), icb_cmd_addr, addr);
      chk($sformatf("%s_cmd_wdata%0d", tag, i), icb_cmd_wdata, wdata);
      chk($sformatf("%s_cmd_wmask%0d", tag, i), icb_cmd_wmask, exp_mask);
      chk($sformatf("%s_cmd_rsp_ready%0d", tag, i), icb_rsp_ready, 1'b0);
      chk($sformatf("%s_cmd_req_ready%0d", tag, i), req_ready, 1'b0);
      icb_cmd_ready = (i == cmd_wait);
      step();
    end
    icb_cmd_ready = 1'b0;
    for (int j = 0; j <= rsp_wait; j++) begin
      chk($sformatf("%s_rsp_cmd_valid%0d", tag, j), icb_cmd_valid, 1'b0);
      chk($sformatf("%s_rsp_ready%0d", tag, j), icb_rsp_ready, 1'b1);
      chk($sformatf("%s_rsp_done%0d", tag, j), done_valid, 1'b0);
      if (j == rsp_wait) begin
        icb_rsp_valid = 1'b1; icb_rsp_rdata = rdata; icb_rsp_err = err;
      end
      step();
    end
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0; icb_rsp_err = 1'b0;
    chk($sformatf("%s_done_valid", tag), done_valid, 1'b1);
    chk($sformatf("%s_done_err", tag), done_err, err);
    chk($sformatf("%s_done_timeout", tag), done_timeout, 1'b0);
    if (exp_q.size() == 0) chk($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
    else chk($sformatf("%s_done_rdata", tag), done_rdata, exp_q.pop_front());
  endtask

  logic [31:0] stream_data [4];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wmask = 4'h0; icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0; icb_rsp_err = 1'b0;
    stream_data[0] = 32'h1111_0001; stream_data[1] = 32'h2222_0002;
    stream_data[2] = 32'h3333_0003; stream_data[3] = 32'h4444_0004;

    step(); step();
    chk("rst_cmd_valid", icb_cmd_valid, 1'b0);
    chk("rst_cmd_addr", icb_cmd_addr, 32'h0);
    chk("rst_cmd_wmask", icb_cmd_wmask, 4'h0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_done_rdata", done_rdata, 32'h0);
    chk("rst_done_err", done_err, 1'b0);
    chk("rst_done_timeout", done_timeout, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_ready", icb_rsp_ready, 1'b1);
    rst_n = 1'b1;

    // zero-wait write, then read with one cmd wait cycle
    do_txn("wr0", 1'b0, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn("rd1", 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0000_00A5, 1'b0);
    step();
    chk("hold_done_valid", done_valid, 1'b0);
    chk("hold_done_rdata", done_rdata, 32'h0000_00A5);

    do_txn("err", 1'b0, 32'h0000_0040, 32'hA5A5_5A5A, 4'h3, 0, 2, 32'h0, 1'b1);
    // response lands in the same cycle the timeout would fire
    do_txn("edge", 1'b1, 32'h0000_0080, 32'h0, 4'hC, 2, 7, 32'hCAFE_F00D, 1'b0);

    // timeout: slave never answers
    step();
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h0000_0300; req_wmask = 4'hF;
    icb_cmd_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("to_cmd_valid", icb_cmd_valid, 1'b1);
    step();
    icb_cmd_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("to_wait_done%0d", j), done_valid, 1'b0);
      chk($sformatf("to_wait_rsp_ready%0d", j), icb_rsp_ready, 1'b1);
      step();
    end
    chk("to_done_valid", done_valid, 1'b1);
    chk("to_done_timeout", done_timeout, 1'b1);
    chk("to_done_err", done_err, 1'b1);
    chk("to_done_rdata", done_rdata, 32'h0);
    step();
    chk("to_done_pulse", done_valid, 1'b0);
    chk("to_req_ready", req_ready, 1'b1);
    icb_rsp_valid = 1'b1; icb_rsp_rdata = 32'h5555_5555;
    chk("late_rsp_ready", icb_rsp_ready, 1'b1);
    step();
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0;
    chk("late_no_done", done_valid, 1'b0);
    chk("late_req_ready", req_ready, 1'b1);
    chk("late_hold_timeout", done_timeout, 1'b1);
    step();
    chk("late_no_done2", done_valid, 1'b0);

    // reset in CMD abandons the transaction
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h0000_0200; icb_cmd_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rc_cmd_valid", icb_cmd_valid, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rc_cmd_valid_off", icb_cmd_valid, 1'b0);
    chk("rc_cmd_addr_clr", icb_cmd_addr, 32'h0);
    chk("rc_no_done", done_valid, 1'b0);
    chk("rc_req_ready", req_ready, 1'b1);

    for (int k = 0; k < 4; k++)
      do_txn($sformatf("bb%0d", k), 1'b1, 32'h0000_1000 + 32'(k * 4), 32'h0, 4'hF,
             k % 2, k, stream_data[k], 1'b0);
    chk("bb_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
